// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, column debounce, one-shot key decode.
// Optional macro KEYPAD_SYNC_EN adds a 2-flop synchronizer on col_n.
module keypad_scanner #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       is_num,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic [3:0] num_val,
  output logic [1:0] op_val
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             is_num_q, is_num_d;
  logic             is_op_q, is_op_d;
  logic             is_eq_q, is_eq_d;
  logic             is_clr_q, is_clr_d;
  logic [3:0]       num_val_q, num_val_d;
  logic [1:0]       op_val_q, op_val_d;
  logic [3:0]       col_s;
  logic             hit;
  logic [1:0]       hit_col;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= col_n;
      sync2_q <= sync1_q;
    end
  end
  assign col_s = sync2_q;
`else
  assign col_s = col_n;
`endif

  // Lowest-index low column wins when several keys share the driven row.
  always_comb begin
    hit     = ~&col_s;
    hit_col = 2'd3;
    if (!col_s[0])      hit_col = 2'd0;
    else if (!col_s[1]) hit_col = 2'd1;
    else if (!col_s[2]) hit_col = 2'd2;
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    div_d     = div_q;
    deb_d     = deb_q;
    is_num_d  = 1'b0;
    is_op_d   = 1'b0;
    is_eq_d   = 1'b0;
    is_clr_d  = 1'b0;
    num_val_d = num_val_q;
    op_val_d  = op_val_q;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (hit) begin
            state_d = DEBOUNCE;
            col_d   = hit_col;
            deb_d   = '0;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s[col_q]) begin
          state_d = SCAN;
          deb_d   = '0;
          row_d   = row_q + 2'd1;
        end else if (deb_q == DEB_MAX) begin
          // Pulses are registered on PRESS entry so they are high during PRESS.
          state_d = PRESS;
          deb_d   = '0;
          if (col_q == 2'd3) begin
            is_op_d  = 1'b1;
            op_val_d = row_q;
          end else if (row_q == 2'd3) begin
            case (col_q)
              2'd0:    is_clr_d = 1'b1;
              2'd1: begin
                is_num_d  = 1'b1;
                num_val_d = 4'd0;
              end
              default: is_eq_d = 1'b1;
            endcase
          end else begin
            is_num_d  = 1'b1;
            num_val_d = 4'(row_q) * 4'd3 + 4'(col_q) + 4'd1;
          end
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESS: begin
        state_d = RELEASE;
        deb_d   = '0;
      end
      RELEASE: begin
        if (col_s != 4'hF) begin
          deb_d = '0;
        end else if (deb_q == DEB_MAX) begin
          state_d = SCAN;
          deb_d   = '0;
          row_d   = row_q + 2'd1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      div_q     <= '0;
      deb_q     <= '0;
      is_num_q  <= 1'b0;
      is_op_q   <= 1'b0;
      is_eq_q   <= 1'b0;
      is_clr_q  <= 1'b0;
      num_val_q <= 4'd0;
      op_val_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      is_num_q  <= is_num_d;
      is_op_q   <= is_op_d;
      is_eq_q   <= is_eq_d;
      is_clr_q  <= is_clr_d;
      num_val_q <= num_val_d;
      op_val_q  <= op_val_d;
    end
  end

  assign row_n   = ~(4'b0001 << row_q);
  assign is_num  = is_num_q;
  assign is_op   = is_op_q;
  assign is_eq   = is_eq_q;
  assign is_clr  = is_clr_q;
  assign num_val = num_val_q;
  assign op_val  = op_val_q;

endmodule
